// File: rtl/alu_arbiter.sv
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Round-robin sharing of one combinational ALU between two requesters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_srca,
  input  logic [N-1:0] req0_srcb,
  input  logic [3:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_srca,
  input  logic [N-1:0] req1_srcb,
  input  logic [3:0]   req1_op,
  output logic [N-1:0] alu_srca,
  output logic [N-1:0] alu_srcb,
  output logic [3:0]   alu_control,
  input  logic [N-1:0] alu_result,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_result,
  output logic         rsp_id,
  output logic         rsp_err,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] c_MAX_LEGAL_OP = 4'd5;

  state_t       state_q;
  logic [N-1:0] srca_q;
  logic [N-1:0] srcb_q;
  logic [3:0]   op_q;
  logic [N-1:0] result_q;
  logic         id_q;
  logic         err_q;
  logic         last_grant_q;

  logic         w_gnt_vld;
  logic         w_gnt_id;
  logic [N-1:0] w_sel_srca;
  logic [N-1:0] w_sel_srcb;
  logic [3:0]   w_sel_op;
  logic         w_sel_legal;

  // Grants are offered only from IDLE; a tie goes to whoever did not win last.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = 1'b0;
    if ((state_q == IDLE) && !reset) begin
      if (req0_valid && req1_valid) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = ~last_grant_q;
      end else if (req0_valid) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = 1'b0;
      end else if (req1_valid) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = 1'b1;
      end
    end
  end

  assign w_sel_srca  = w_gnt_id ? req1_srca : req0_srca;
  assign w_sel_srcb  = w_gnt_id ? req1_srcb : req0_srcb;
  assign w_sel_op    = w_gnt_id ? req1_op   : req0_op;
  assign w_sel_legal = (w_sel_op <= c_MAX_LEGAL_OP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      srca_q       <= '0;
      srcb_q       <= '0;
      op_q         <= '0;
      result_q     <= '0;
      id_q         <= 1'b0;
      err_q        <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_gnt_vld) begin
            srca_q       <= w_sel_srca;
            srcb_q       <= w_sel_srcb;
            op_q         <= w_sel_op;
            id_q         <= w_gnt_id;
            last_grant_q <= w_gnt_id;
            if (w_sel_legal) begin
              state_q <= EXEC;
            end else begin
              // Illegal codes skip the ALU and answer with an error right away.
              result_q <= '0;
              err_q    <= 1'b1;
              state_q  <= RESP;
            end
          end
        end
        EXEC: begin
          result_q <= alu_result;
          err_q    <= 1'b0;
          state_q  <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req0_ready  = w_gnt_vld & ~w_gnt_id;
  assign req1_ready  = w_gnt_vld &  w_gnt_id;
  assign alu_srca    = srca_q;
  assign alu_srcb    = srcb_q;
  assign alu_control = op_q;
  assign rsp_valid   = (state_q == RESP) && !reset;
  assign rsp_result  = result_q;
  assign rsp_id      = id_q;
  assign rsp_err     = err_q;
  assign busy        = (state_q != IDLE) && !reset;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Randomized and directed bench for alu_arbiter with a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_srca = '0, req0_srcb = '0, req1_srca = '0, req1_srcb = '0;
  logic [3:0]  req0_op = '0, req1_op = '0;
  logic [31:0] alu_srca, alu_srcb, alu_result, rsp_result;
  logic [3:0]  alu_control;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_err, busy;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.N(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_srca(req0_srca), .req0_srcb(req0_srcb), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_srca(req1_srca), .req1_srcb(req1_srcb), .req1_op(req1_op),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_control(alu_control),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy)
  );

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return (b >= 32) ? 32'd0 : (a << b[4:0]);
      4'd3: return (b >= 32) ? 32'd0 : (a >> b[4:0]);
      4'd4: return a & b;
      4'd5: return a | b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // External ALU; illegal codes return a poison value that must never surface.
  assign alu_result = alu_f(alu_srca, alu_srcb, alu_control);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: at most one outstanding operation, visible from cycle m_rdy.
  bit          model_on = 0;
  longint      cyc = 0;
  bit          m_out = 0;
  bit          m_last = 1;
  longint      m_rdy = 0;
  logic [31:0] m_a = 0, m_b = 0, m_res = 0;
  logic [3:0]  m_op = 0;
  bit          m_id = 0, m_err = 0;

  function automatic bit model_grant();
    if (req0_valid && req1_valid) return ~m_last;
    return req1_valid && !req0_valid;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_out = 0; m_last = 1; m_a = 0; m_b = 0; m_op = 0;
      model_on = 1;
    end else if (model_on) begin
      if (m_out) begin
        if (cyc >= m_rdy && rsp_ready) m_out = 0;
      end else if (req0_valid || req1_valid) begin
        bit g;
        g     = model_grant();
        m_a   = g ? req1_srca : req0_srca;
        m_b   = g ? req1_srcb : req0_srcb;
        m_op  = g ? req1_op : req0_op;
        m_id  = g;
        m_last = g;
        m_out = 1;
        m_err = (m_op > 4'd5);
        m_res = m_err ? 32'd0 : alu_f(m_a, m_b, m_op);
        m_rdy = cyc + (m_err ? 1 : 2);
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (model_on) begin
      if (reset) begin
        chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
        chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
      end else begin
        chk("alu_srca", alu_srca, m_a);
        chk("alu_srcb", alu_srcb, m_b);
        chk("alu_control", {28'd0, alu_control}, {28'd0, m_op});
        chk("busy", {31'd0, busy}, {31'd0, m_out});
        if (m_out) begin
          chk("ready0_busy", {31'd0, req0_ready}, 32'd0);
          chk("ready1_busy", {31'd0, req1_ready}, 32'd0);
          chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, (cyc >= m_rdy)});
          if (cyc >= m_rdy) begin
            chk("rsp_result", rsp_result, m_res);
            chk("rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, m_err});
          end
        end else begin
          bit any, g;
          any = req0_valid || req1_valid;
          g   = model_grant();
          chk("ready0", {31'd0, req0_ready}, {31'd0, any && !g});
          chk("ready1", {31'd0, req1_ready}, {31'd0, any && g});
          chk("rsp_valid_idle", {31'd0, rsp_valid}, 32'd0);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input bit who, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op);
    if (who) begin
      req1_valid = 1; req1_srca = a; req1_srcb = b; req1_op = op;
    end else begin
      req0_valid = 1; req0_srca = a; req0_srcb = b; req0_op = op;
    end
  endtask

  task automatic accept(input bit who, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op);
    bit got;
    got = 0;
    set_req(who, a, b, op);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = who ? req1_ready : req0_ready;
      step();
    end
    if (who) req1_valid = 0; else req0_valid = 0;
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_one(input string name, input bit who, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] op,
                         input logic [31:0] exp_res, input bit exp_err, input int exp_lat);
    int  lat;
    bit  seen;
    lat = 0; seen = 0;
    accept(who, a, b, op);
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      #1;
      lat++;
      if (rsp_valid) seen = 1;
      else step();
    end
    chk({name, "_lat"}, lat, exp_lat);
    chk({name, "_res"}, rsp_result, exp_res);
    chk({name, "_id"}, {31'd0, rsp_id}, {31'd0, who});
    chk({name, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    step();
  endtask

  initial begin
    int          grants[$];
    logic [31:0] results[$];
    bit          a0, a1;

    rsp_ready = 1;
    repeat (3) step();
    reset = 0;

    run_one("add5p7", 0, 32'd5, 32'd7, 4'd0, 32'd12, 0, 2);

    // Alternating grants from a fresh reset with both requesters always valid.
    reset = 1; step(); reset = 0;
    set_req(0, 32'd10, 32'd3, 4'd1);
    set_req(1, 32'hF0, 32'h0F, 4'd5);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      #1;
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
      if (rsp_valid) results.push_back(rsp_result);
      step();
    end
    req0_valid = 0; req1_valid = 0;
    if (grants.size() >= 4 && results.size() >= 2) begin
      chk("alt_g0", grants[0], 0);
      chk("alt_g1", grants[1], 1);
      chk("alt_g2", grants[2], 0);
      chk("alt_g3", grants[3], 1);
      chk("alt_r0", results[0], 32'd7);
      chk("alt_r1", results[1], 32'hFF);
    end else begin
      chk("alt_count", grants.size(), 4);
    end
    repeat (4) step();

    run_one("illegal", 1, 32'h1234, 32'h5678, 4'b1001, 32'd0, 1, 1);

    // Backpressure: response held while a second req0 waits.
    rsp_ready = 0;
    accept(0, 32'd1, 32'd4, 4'd2);
    set_req(0, 32'd2, 32'd3, 4'd0);
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("bp_result", rsp_result, 32'd16);
      chk("bp_busy", {31'd0, busy}, 32'd1);
      chk("bp_ready0", {31'd0, req0_ready}, 32'd0);
      step();
    end
    rsp_ready = 1;
    @(negedge clk); #1;
    chk("bp_ready0_resp", {31'd0, req0_ready}, 32'd0);
    step();
    @(negedge clk); #1;
    chk("bp_ready0_granted", {31'd0, req0_ready}, 32'd1);
    step();
    req0_valid = 0;
    repeat (4) step();

    run_one("wrap_add", 0, 32'hFFFF_FFFF, 32'd1, 4'd0, 32'd0, 0, 2);
    run_one("wrap_sub", 1, 32'd0, 32'd1, 4'd1, 32'hFFFF_FFFF, 0, 2);
    run_one("srl31", 0, 32'h8000_0000, 32'd31, 4'd3, 32'd1, 0, 2);
    run_one("sll32", 1, 32'd1, 32'd32, 4'd2, 32'd0, 0, 2);

    // Reset while the operation is in EXEC.
    accept(1, 32'd9, 32'd9, 4'd0);
    reset = 1;
    @(negedge clk); #1;
    chk("rexec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    step();
    reset = 0;
    set_req(0, 32'd1, 32'd1, 4'd4);
    set_req(1, 32'd2, 32'd2, 4'd4);
    @(negedge clk); #1;
    chk("rexec_busy", {31'd0, busy}, 32'd0);
    chk("rexec_rsp_valid2", {31'd0, rsp_valid}, 32'd0);
    chk("rexec_ready0", {31'd0, req0_ready}, 32'd1);
    step();
    req0_valid = 0;

    // Randomized traffic obeying the hold-until-ready rule.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      #1;
      a0 = req0_ready;
      a1 = req1_ready;
      step();
      if (!req0_valid || a0) begin
        req0_valid = ($urandom % 3) != 0;
        req0_srca  = $urandom;
        req0_srcb  = ($urandom % 3 == 0) ? ($urandom % 40) : $urandom;
        req0_op    = ($urandom % 8 == 0) ? 4'($urandom % 16) : 4'($urandom % 6);
      end
      if (!req1_valid || a1) begin
        req1_valid = ($urandom % 3) != 0;
        req1_srca  = $urandom;
        req1_srcb  = ($urandom % 3 == 0) ? ($urandom % 40) : $urandom;
        req1_op    = ($urandom % 8 == 0) ? 4'($urandom % 16) : 4'($urandom % 6);
      end
      rsp_ready = ($urandom % 4) != 0;
      reset     = ($urandom % 60) == 0;
    end

    reset = 0; req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    repeat (6) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
